// File: rtl/decoder_hold_if.sv
// Code-in / one-hot-out bus between an encoder-side producer and decoder_hold.
interface decoder_hold_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned W = 1 << N;

  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         busy;

  modport master (
    output din, din_valid,
    input  din_ready, dout, dout_valid, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dout, dout_valid, busy
  );
endinterface

// File: rtl/decoder_hold.sv
// Registered binary-to-one-hot decoder; each code is held on dout for HOLD
// cycles, with a one-entry pending slot for gapless back-to-back codes.
module decoder_hold #(
  parameter int unsigned N    = 3,
  parameter int unsigned HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  decoder_hold_if.slave  bus
);
  localparam int unsigned W        = 1 << N;
  localparam logic [7:0]  CNT_LOAD = 8'(HOLD - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t       state;
  logic [7:0]   cnt;
  logic [N-1:0] pend;
  logic         pend_v;
  logic [W-1:0] dout_q;
  logic         dout_valid_q;
  logic         busy_q;
  logic         last;
  logic         accept;

  // The pending slot may refill in the same cycle it drains into the output.
  assign last          = (state == ACTIVE) && (cnt == 8'd0);
  assign bus.din_ready = !pend_v || last;
  assign accept        = bus.din_valid && bus.din_ready;

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;

  // dout_q holds the active code in one-hot form; it doubles as the cur register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      pend         <= '0;
      pend_v       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= ACTIVE;
            cnt          <= CNT_LOAD;
            dout_q       <= W'(1) << bus.din;
            dout_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
            if (accept) begin
              pend   <= bus.din;
              pend_v <= 1'b1;
            end
          end else if (pend_v) begin
            cnt    <= CNT_LOAD;
            dout_q <= W'(1) << pend;
            if (accept) begin
              pend <= bus.din;
            end else begin
              pend_v <= 1'b0;
            end
          end else if (accept) begin
            cnt    <= CNT_LOAD;
            dout_q <= W'(1) << bus.din;
          end else begin
            state        <= IDLE;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_decoder_hold.sv
// Directed bench for decoder_hold: HOLD=4 and HOLD=1 instances.
module tb_decoder_hold;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decoder_hold_if #(.N(3)) bus4 ();
  decoder_hold_if #(.N(3)) bus1 ();

  decoder_hold #(.N(3), .HOLD(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));
  decoder_hold #(.N(3), .HOLD(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back trace (2,7,3): dout and din_ready after each edge E0..E12.
  logic [7:0] bb_dout  [13] = '{8'h04, 8'h04, 8'h04, 8'h04,
                                8'h80, 8'h80, 8'h80, 8'h80,
                                8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
  logic       bb_ready [13] = '{1'b1, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [2:0] bb_code  [3]  = '{3'd2, 3'd7, 3'd3};
  logic [7:0] onehot;

  initial begin
    bus4.din = 3'd0; bus4.din_valid = 1'b0;
    bus1.din = 3'd0; bus1.din_valid = 1'b0;
    #1;

    // Reset with din_valid asserted: nothing is accepted.
    rst = 1'b1; bus4.din = 3'd3; bus4.din_valid = 1'b1;
    tick(); tick();
    rst = 1'b0; bus4.din_valid = 1'b0;
    check("rst_dout",   32'(bus4.dout), 32'h00);
    check("rst_dvalid", 32'(bus4.dout_valid), 32'd0);
    check("rst_busy",   32'(bus4.busy), 32'd0);
    check("rst_ready",  32'(bus4.din_ready), 32'd1);
    tick();
    check("rst_noacc",  32'(bus4.dout), 32'h00);

    // Single code 5 held for 4 cycles.
    bus4.din = 3'd5; bus4.din_valid = 1'b1;
    tick();
    bus4.din_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("single_dout", 32'(bus4.dout), (k < 4) ? 32'h20 : 32'h00);
      check("single_dv",   32'(bus4.dout_valid), (k < 4) ? 32'd1 : 32'd0);
      check("single_busy", 32'(bus4.busy), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end

    // Sweep every code with idle gaps.
    for (int c = 0; c < 8; c++) begin
      bus4.din = 3'(c); bus4.din_valid = 1'b1;
      tick();
      bus4.din_valid = 1'b0;
      onehot = 8'd1 << c;
      for (int k = 0; k < 7; k++) begin
        check("sweep_dout", 32'(bus4.dout), (k < 4) ? 32'(onehot) : 32'h00);
        check("sweep_onehot", 32'($onehot0(bus4.dout)), 32'd1);
        tick();
      end
    end

    // Back-to-back with din_valid held; the bench advances on each handshake.
    begin
      int  idx = 0;
      logic acc;
      bus4.din = bb_code[0]; bus4.din_valid = 1'b1;
      for (int i = 0; i < 13; i++) begin
        acc = bus4.din_valid && bus4.din_ready;
        tick();
        if (acc) idx++;
        if (idx < 3) bus4.din = bb_code[idx];
        else bus4.din_valid = 1'b0;
        check($sformatf("b2b_dout%0d", i), 32'(bus4.dout), 32'(bb_dout[i]));
        check($sformatf("b2b_ready%0d", i), 32'(bus4.din_ready), 32'(bb_ready[i]));
      end
      check("b2b_all_sent", 32'(idx), 32'd3);
      check("b2b_idle_busy", 32'(bus4.busy), 32'd0);
    end

    // HOLD=1 continuous stream.
    bus1.din = 3'd0; bus1.din_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check("h1_ready", 32'(bus1.din_ready), 32'd1);
      tick();
      if (c < 7) bus1.din = 3'(c + 1);
      else bus1.din_valid = 1'b0;
      onehot = 8'd1 << c;
      check("h1_dout", 32'(bus1.dout), 32'(onehot));
    end
    tick();
    check("h1_end_dout", 32'(bus1.dout), 32'h00);
    check("h1_end_busy", 32'(bus1.busy), 32'd0);

    // Reset mid-hold: 6 active at cnt=2 with 1 pending.
    bus4.din = 3'd6; bus4.din_valid = 1'b1;
    tick();
    bus4.din = 3'd1;
    tick();
    bus4.din_valid = 1'b0;
    check("mid_pre_dout",  32'(bus4.dout), 32'h40);
    check("mid_pre_ready", 32'(bus4.din_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_dout",  32'(bus4.dout), 32'h00);
    check("mid_busy",  32'(bus4.busy), 32'd0);
    check("mid_dv",    32'(bus4.dout_valid), 32'd0);
    check("mid_ready", 32'(bus4.din_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mid_nopend", 32'(bus4.dout), 32'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
